// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined add/subtract unit with valid/ready handshake
//
// A WIDTH-bit add or subtract is cut into STAGES slices of SW = WIDTH/STAGES
// bits. Stage k adds slice k using the carry registered by stage k-1, so the
// pipeline delivers one result per cycle at a fixed latency of STAGES cycles.
// WIDTH must be >= 1, STAGES >= 1, and STAGES must divide WIDTH.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   a, b, carry_in, sub valid this cycle
//   in_ready   pipeline accepts an input this cycle (combinational from out_ready)
//   a, b       operands (unsigned or two's complement)
//   carry_in   carry into bit 0 (borrow-in when sub = 1)
//   sub        0 = add, 1 = subtract
//   out_valid  sum, carry_out, overflow valid
//   out_ready  consumer takes the result this cycle
//   sum        result modulo 2^WIDTH
//   carry_out  raw carry out of bit WIDTH-1 (1 = no borrow in subtract mode)
//   overflow   signed overflow
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SW = WIDTH / STAGES;

  // The whole pipeline moves as one shift register: either every stage
  // advances or every stage holds. Bubbles are not compacted during a stall.
  logic             adv;
  logic [WIDTH-1:0] bx_in;
  logic             cin_in;

  assign bx_in  = sub ? ~b : b;
  assign cin_in = carry_in ^ sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * SW;
    localparam int REM  = WIDTH - DONE;

    logic            vld_in;
    logic            cy_in;
    logic [SW-1:0]   a_sl;
    logic [SW-1:0]   b_sl;
    logic [SW:0]     slice_sum;
    logic [DONE-1:0] sum_d;
    logic [DONE-1:0] sum_q;
    logic            vld_q;
    logic            cy_q;

    if (k == 0) begin : g_src
      assign vld_in = in_valid;
      assign cy_in  = cin_in;
      assign a_sl   = a[SW-1:0];
      assign b_sl   = bx_in[SW-1:0];
      assign sum_d  = slice_sum[SW-1:0];
    end else begin : g_src
      // Operand slice k was skew-delayed by the earlier stages so it lines up
      // with the carry coming out of stage k-1.
      assign vld_in = g_stage[k-1].vld_q;
      assign cy_in  = g_stage[k-1].cy_q;
      assign a_sl   = g_stage[k-1].g_ops.a_rem_q[SW-1:0];
      assign b_sl   = g_stage[k-1].g_ops.b_rem_q[SW-1:0];
      assign sum_d  = {slice_sum[SW-1:0], g_stage[k-1].sum_q};
    end

    assign slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SW{1'b0}}, cy_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        vld_q <= vld_in;
        cy_q  <= slice_sum[SW];
        sum_q <= sum_d;
      end
    end

    // Operand bits not yet consumed travel alongside; each stage peels off
    // the lowest slice, so the register shrinks by SW bits per stage.
    if (k < STAGES - 1) begin : g_ops
      logic [REM-1:0] a_rem_d;
      logic [REM-1:0] b_rem_d;
      logic [REM-1:0] a_rem_q;
      logic [REM-1:0] b_rem_q;

      if (k == 0) begin : g_first
        assign a_rem_d = a[WIDTH-1:SW];
        assign b_rem_d = bx_in[WIDTH-1:SW];
      end else begin : g_next
        assign a_rem_d = g_stage[k-1].g_ops.a_rem_q[REM+SW-1:SW];
        assign b_rem_d = g_stage[k-1].g_ops.b_rem_q[REM+SW-1:SW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else if (adv) begin
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end

    // Carry into the MSB is recovered as a ^ bx ^ sum at that bit, so the
    // signed overflow needs no extra carry tap inside the slice adder.
    if (k == STAGES - 1) begin : g_last
      logic ovf_d;
      logic ovf_q;

      assign ovf_d = a_sl[SW-1] ^ b_sl[SW-1] ^ slice_sum[SW-1] ^ slice_sum[SW];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign carry_out = g_stage[STAGES-1].cy_q;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_q;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

endmodule
